ssd_scan: RTL

Four-digit seven-segment scan controller that sits directly upstream of the per-digit segment decoder. Holds a 16-bit BCD value, time-multiplexes one nibble at a time onto the decoder's 4-bit digit input, and drives the matching active-low digit-enable lines. New values are taken with a load strobe and committed only at frame boundaries, so a digit never changes mid-frame.

---
 rtl/ssd_pkg.sv | 9 +
 rtl/ssd_tick_gen.sv | 20 ++
 rtl/ssd_scan.sv | 77 +++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and types for the seven-segment scan controller
package ssd_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 4;

  typedef logic [1:0] slot_t;

  localparam logic [NUM_DIGITS-1:0] ALL_OFF = 4'b1111;
endpackage

// File: rtl/ssd_tick_gen.sv
// rtl/ssd_tick_gen.sv - free-running refresh prescaler, tick on the all-ones count
module tick_gen #(
  parameter int DIV_BITS = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);
  logic [DIV_BITS-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = &r_cnt;
endmodule

// File: rtl/ssd_scan.sv
// rtl/ssd_scan.sv - four-digit scan with frame-aligned commit; LEADING_ZERO_BLANK_EN blanks leading zeros
module ssd_scan
  import ssd_pkg::*;
#(
  parameter int DIV_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIG_W-1:0]   bcd_in,
  output logic [DIG_W-1:0]              dig,
  output logic [NUM_DIGITS-1:0]         ssd_ctl,
  output logic                          pending,
  output logic                          frame_done
);
  logic                        w_tick;
  logic                        w_wrap;
  logic [NUM_DIGITS-1:0]       w_onehot_n;
  slot_t                       r_idx;
  logic [NUM_DIGITS*DIG_W-1:0] r_shadow;
  logic [NUM_DIGITS*DIG_W-1:0] r_disp;
  logic                        r_pending;
  logic                        r_frame_done;

  tick_gen #(.DIV_BITS(DIV_BITS)) u_tick_gen (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_tick  (w_tick)
  );

  assign w_wrap = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_shadow     <= '0;
      r_disp       <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      if (load) begin
        r_shadow <= bcd_in;
      end
      // A load landing on the wrap edge bypasses the shadow so it shows next frame.
      if (w_wrap && (load || r_pending)) begin
        r_disp    <= load ? bcd_in : r_shadow;
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign w_onehot_n = ~(4'b0001 << r_idx);
  assign dig        = r_disp[{r_idx, 2'b00} +: DIG_W];
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_blank;

  always_comb begin
    w_blank    = '0;
    w_blank[3] = (r_disp[15:12] == 4'h0);
    w_blank[2] = w_blank[3] && (r_disp[11:8] == 4'h0);
    w_blank[1] = w_blank[2] && (r_disp[7:4] == 4'h0);
  end

  assign ssd_ctl = w_blank[r_idx] ? ALL_OFF : w_onehot_n;
`else
  assign ssd_ctl = w_onehot_n;
`endif
endmodule
